// File: rtl/pscan_pkg.sv
// Shared FSM state type, default parameter values and the pattern length clamp
// used by the pattern_scan_ctrl slice.
package pscan_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int PAT_MAX_DEF = 8;
   localparam int CNT_W_DEF   = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_EOF   = 2'd2
   } state_e;

   // Folds any requested length into the legal range 1..pat_max.
   function automatic int clamp_len(input int len, input int pat_max);
      if (len < 1) return 1;
      if (len > pat_max) return pat_max;
      return len;
   endfunction

endpackage

// File: rtl/pscan_matcher.sv
// Serial pattern matcher: bit history, saturating history count, masked compare,
// overlap handling and a registered one-cycle hit pulse.
module pscan_matcher
   import pscan_pkg::*;
#(
   parameter  int PAT_MAX = PAT_MAX_DEF,
   localparam int LEN_W   = $clog2(PAT_MAX + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               bit_valid,
   input  logic               bit_in,
   input  logic [PAT_MAX-1:0] pattern,
   input  logic [PAT_MAX-1:0] mask,
   input  logic [LEN_W-1:0]   len,
   input  logic               overlap,
   output logic               hit
);

   logic [PAT_MAX-1:0] hist_q, hist_d;
   logic [PAT_MAX-1:0] shifted;
   logic [PAT_MAX-1:0] len_mask;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [LEN_W-1:0]   cnt_inc;
   logic               match;
   logic               hit_q, hit_d;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      hist_d   = hist_q;
      cnt_d    = cnt_q;
      match    = 1'b0;
      len_mask = '0;
      for (int i = 0; i < PAT_MAX; i++) len_mask[i] = (i < int'(len));
      shifted  = {hist_q[PAT_MAX-2:0], bit_in};
      cnt_inc  = (cnt_q >= len) ? len : cnt_q + LEN_W'(1);

      if (clear) begin
         hist_d = '0;
         cnt_d  = '0;
      end else if (bit_valid) begin
         hist_d = shifted;
         cnt_d  = cnt_inc;
         match  = (cnt_inc >= len) && (((shifted ^ pattern) & mask & len_mask) == '0);
         if (match && !overlap) cnt_d = '0;
      end
      hit_d = match;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst) begin
         hist_q <= '0;
         cnt_q  <= '0;
         hit_q  <= 1'b0;
      end else begin
         hist_q <= hist_d;
         cnt_q  <= cnt_d;
         hit_q  <= hit_d;
      end
   end

   assign hit = hit_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word-to-bit serializer with programmable pattern match, hit counter and sticky irq.
// Optional don't-care mask on the compare is enabled by defining PSCAN_MASK_EN.
module pattern_scan_ctrl
   import pscan_pkg::*;
#(
   parameter  int DATA_W  = DATA_W_DEF,
   parameter  int PAT_MAX = PAT_MAX_DEF,
   parameter  int CNT_W   = CNT_W_DEF,
   localparam int LEN_W   = $clog2(PAT_MAX + 1),
   localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [PAT_MAX-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic [CNT_W-1:0]   cfg_thresh,
`ifdef PSCAN_MASK_EN
   input  logic [PAT_MAX-1:0] cfg_mask,
`endif
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_last,
   output logic               in_ready,
   output logic               bit_valid,
   output logic               bit_out,
   output logic               hit,
   output logic [CNT_W-1:0]   hit_count,
   output logic               irq,
   input  logic               irq_clr,
   output logic               busy
);

   state_e             state_q, state_d;
   logic [DATA_W-1:0]  word_q, word_d;
   logic               last_q, last_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [PAT_MAX-1:0] pat_q, pat_d;
   logic [PAT_MAX-1:0] mask_q, mask_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [CNT_W-1:0]   thr_q, thr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               irq_q, irq_d;
   logic               cfg_accept;
   logic               xfer;

   assign cfg_accept = (state_q == ST_IDLE) && cfg_we;
   assign in_ready   = rst && (state_q == ST_IDLE) && !cfg_we;
   assign xfer       = in_valid && in_ready;
   assign bit_valid  = (state_q == ST_SHIFT);
   assign bit_out    = bit_valid && word_q[idx_q];
   assign busy       = (state_q != ST_IDLE);
   assign hit_count  = cnt_q;
   assign irq        = irq_q;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      last_d  = last_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: if (xfer) begin
            word_d  = in_data;
            last_d  = in_last;
            idx_d   = IDX_W'(DATA_W - 1);
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (idx_q == '0) state_d = last_q ? ST_EOF : ST_IDLE;
            else             idx_d   = idx_q - IDX_W'(1);
         end
         ST_EOF:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pat_d  = pat_q;
      mask_d = mask_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      thr_d  = thr_q;
      if (cfg_accept) begin
         pat_d = cfg_pattern;
         len_d = LEN_W'(clamp_len(int'(cfg_len), PAT_MAX));
         ovl_d = cfg_overlap;
         thr_d = cfg_thresh;
`ifdef PSCAN_MASK_EN
         mask_d = cfg_mask;
`else
         mask_d = '1;
`endif
      end
   end

   // irq only fires on the increment that lands on the threshold; a set beats irq_clr.
   always_comb begin
      cnt_d = cnt_q;
      irq_d = irq_q && !irq_clr;
      if (cfg_accept) begin
         cnt_d = '0;
         irq_d = 1'b0;
      end else if (hit && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
         if ((thr_q != '0) && (cnt_d == thr_q)) irq_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         last_q  <= 1'b0;
         idx_q   <= '0;
         pat_q   <= '0;
         mask_q  <= '1;
         len_q   <= LEN_W'(1);
         ovl_q   <= 1'b0;
         thr_q   <= '0;
         cnt_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         pat_q   <= pat_d;
         mask_q  <= mask_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         thr_q   <= thr_d;
         cnt_q   <= cnt_d;
         irq_q   <= irq_d;
      end
   end

   pscan_matcher #(.PAT_MAX(PAT_MAX)) u_matcher (
      .clk       (clk),
      .rst       (rst),
      .clear     (cfg_accept || (state_q == ST_EOF)),
      .bit_valid (bit_valid),
      .bit_in    (bit_out),
      .pattern   (pat_q),
      .mask      (mask_q),
      .len       (len_q),
      .overlap   (ovl_q),
      .hit       (hit)
   );

endmodule
